// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master Wishbone classic arbiter with data priority and watchdog
module wb_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_adr_i,
  input  logic            i_cyc_i,
  input  logic            i_stb_i,
  output logic [DW-1:0]   i_dat_o,
  output logic            i_ack_o,
  output logic            i_err_o,
  input  logic [AW-1:0]   d_adr_i,
  input  logic [DW-1:0]   d_dat_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic            d_cyc_i,
  input  logic            d_stb_i,
  output logic [DW-1:0]   d_dat_o,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int STW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [STW-1:0] STREAK_MAX = STW'(MAX_DSTREAK);
  localparam logic [WDW-1:0] WDOG_LAST  = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

  state_t         state, state_nx;
  logic [STW-1:0] streak;
  logic [WDW-1:0] wdog;
  logic           abort_d;   // owner at abort time was the data port
  logic           req_i, req_d, resp, wdog_hit;

  assign req_i    = i_cyc_i & i_stb_i;
  assign req_d    = d_cyc_i & d_stb_i;
  assign resp     = s_ack_i | s_err_i;
  assign wdog_hit = (TIMEOUT != 0) && (wdog == WDOG_LAST);

  // read data is shared; only ack/err decide who consumes it
  assign i_dat_o = s_dat_i;
  assign d_dat_o = s_dat_i;

  // state, fairness streak, watchdog and abort-owner registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= '0;
      wdog    <= '0;
      abort_d <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (!req_i || state_nx == GNT_I)
          streak <= '0;
        else if (state_nx == GNT_D && streak != STREAK_MAX)
          streak <= streak + 1'b1;
      end
      if (state == IDLE)
        wdog <= '0;
      else if (state == GNT_I || state == GNT_D)
        wdog <= wdog + 1'b1;
      if (state_nx == ABORT)
        abort_d <= (state == GNT_D);
    end
  end

  // next-state arbitration and slave/master routing
  always_comb begin
    state_nx  = state;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    unique case (state)
      IDLE: begin
        // data wins unless instruction fetch has been starved for a full streak
        if (req_d && !(req_i && streak == STREAK_MAX))
          state_nx = GNT_D;
        else if (req_i)
          state_nx = GNT_I;
      end
      GNT_I: begin
        grant_o = 2'b01;
        s_adr_o = i_adr_i;
        s_sel_o = '1;
        s_cyc_o = i_cyc_i;
        s_stb_o = i_stb_i;
        i_ack_o = s_ack_i;
        i_err_o = s_err_i;
        if (!i_cyc_i || resp)
          state_nx = IDLE;
        else if (wdog_hit)
          state_nx = ABORT;
      end
      GNT_D: begin
        grant_o = 2'b10;
        s_adr_o = d_adr_i;
        s_dat_o = d_dat_i;
        s_we_o  = d_we_i;
        s_sel_o = d_sel_i;
        s_cyc_o = d_cyc_i;
        s_stb_o = d_stb_i;
        d_ack_o = s_ack_i;
        d_err_o = s_err_i;
        if (!d_cyc_i || resp)
          state_nx = IDLE;
        else if (wdog_hit)
          state_nx = ABORT;
      end
      ABORT: begin
        timeout_o = 1'b1;
        if (abort_d)
          d_err_o = 1'b1;
        else
          i_err_o = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - self-checking bench for wb_mem_arbiter
module tb_wb_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4, TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] i_adr_i, d_adr_i, s_adr_o;
  logic [DW-1:0] i_dat_o, d_dat_i, d_dat_o, s_dat_o, s_dat_i;
  logic i_cyc_i, i_stb_i, i_ack_o, i_err_o;
  logic d_we_i, d_cyc_i, d_stb_i, d_ack_o, d_err_o;
  logic [3:0] d_sel_i, s_sel_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, timeout_o;
  logic [1:0] grant_o;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] rdat;
    int          waits;
    logic        err;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    i_adr_i = '0; i_cyc_i = 0; i_stb_i = 0;
    d_adr_i = '0; d_dat_i = '0; d_we_i = 0; d_sel_i = '0; d_cyc_i = 0; d_stb_i = 0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic go_idle();
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v, input int k);
    tick();
    d_we_i = v.we; d_sel_i = v.sel; d_dat_i = v.wdat;
    if (v.is_d) begin d_cyc_i = 1; d_stb_i = 1; d_adr_i = v.adr; end
    else begin i_cyc_i = 1; i_stb_i = 1; i_adr_i = v.adr; end
    for (int w = 0; w <= v.waits; w++) begin
      tick();
      if (w == v.waits) begin
        s_dat_i = v.rdat;
        if (v.err) s_err_i = 1; else s_ack_i = 1;
      end
      #1;
      if (w == 0) begin
        chk($sformatf("vec%0d grant", k), grant_o, v.exp_grant);
        chk($sformatf("vec%0d s_adr", k), s_adr_o, v.adr);
        chk($sformatf("vec%0d s_we", k), s_we_o, v.exp_we);
        chk($sformatf("vec%0d s_sel", k), s_sel_o, v.exp_sel);
        chk($sformatf("vec%0d s_cyc", k), s_cyc_o, 1'b1);
        if (v.is_d) chk($sformatf("vec%0d s_dat", k), s_dat_o, v.wdat);
      end
    end
    if (v.is_d) begin
      chk($sformatf("vec%0d ack/err", k), {d_ack_o, d_err_o}, {~v.err, v.err});
      chk($sformatf("vec%0d other", k), {i_ack_o, i_err_o}, 2'b00);
      chk($sformatf("vec%0d dat", k), d_dat_o, v.rdat);
    end else begin
      chk($sformatf("vec%0d ack/err", k), {i_ack_o, i_err_o}, {~v.err, v.err});
      chk($sformatf("vec%0d other", k), {d_ack_o, d_err_o}, 2'b00);
      chk($sformatf("vec%0d dat", k), i_dat_o, v.rdat);
    end
    tick();
    idle_inputs();
    #1;
    chk($sformatf("vec%0d idle grant", k), grant_o, 2'b00);
  endtask

  // cycle-level reference: owner, wait count and streak derived from the arbitration rules
  task automatic run_random(input int n);
    int owner, streak, waited, who;
    bit ab, quiet, cyc, ri, rd;
    logic [8:0] exp_ctrl;
    owner = 0; streak = 0; waited = 0; who = 0; ab = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      quiet = (c % 150) < 12;
      i_cyc_i = quiet || ($urandom_range(0, 3) != 0);
      i_stb_i = i_cyc_i && (quiet || $urandom_range(0, 7) != 0);
      d_cyc_i = quiet || ($urandom_range(0, 3) != 0);
      d_stb_i = d_cyc_i && (quiet || $urandom_range(0, 7) != 0);
      i_adr_i = $urandom; d_adr_i = $urandom; d_dat_i = $urandom; s_dat_i = $urandom;
      d_we_i = $urandom_range(0, 1); d_sel_i = 4'($urandom_range(0, 15));
      s_ack_i = !quiet && ($urandom_range(0, 9) < 3);
      s_err_i = !quiet && ($urandom_range(0, 19) == 0);
      #1;
      exp_ctrl = '0;
      if (ab) begin
        exp_ctrl[0] = 1;
        if (who == 2) exp_ctrl[1] = 1; else exp_ctrl[3] = 1;
      end else if (owner == 1) begin
        exp_ctrl = {2'b01, i_cyc_i, i_stb_i, s_ack_i, s_err_i, 3'b000};
      end else if (owner == 2) begin
        exp_ctrl = {2'b10, d_cyc_i, d_stb_i, 2'b00, s_ack_i, s_err_i, 1'b0};
      end
      chk($sformatf("rand ctrl c%0d", c),
          {grant_o, s_cyc_o, s_stb_o, i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o}, exp_ctrl);
      if (!ab && owner == 1)
        chk($sformatf("rand ibus c%0d", c), {s_adr_o, s_we_o, s_sel_o}, {i_adr_i, 1'b0, 4'hF});
      if (!ab && owner == 2)
        chk($sformatf("rand dbus c%0d", c), {s_adr_o, s_we_o, s_sel_o, s_dat_o[15:0]},
            {d_adr_i, d_we_i, d_sel_i, d_dat_i[15:0]});
      if (ab) begin
        ab = 0; owner = 0;
      end else if (owner != 0) begin
        cyc = (owner == 1) ? i_cyc_i : d_cyc_i;
        if (!cyc || s_ack_i || s_err_i) owner = 0;
        else if (waited == TO - 1) begin ab = 1; who = owner; owner = 0; end
        else waited++;
      end else begin
        ri = i_cyc_i && i_stb_i;
        rd = d_cyc_i && d_stb_i;
        if (!ri) streak = 0;
        if (rd && !(ri && streak == MAXS)) begin owner = 2; if (ri) streak++; end
        else if (ri) begin owner = 1; streak = 0; end
        waited = 0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [1:0] exp_order[10];
    logic [1:0] g;
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 4'h3, 32'h1111_2222, 0, 1'b0, 2'b01, 1'b0, 4'hF};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'h0,         1'b0, 4'hF, 32'h3333_4444, 1, 1'b0, 2'b10, 1'b0, 4'hF};
    vecs[2] = '{1'b1, 32'h0000_2004, 32'hA5A5_5A5A, 1'b1, 4'h6, 32'h0,         3, 1'b0, 2'b10, 1'b1, 4'h6};
    vecs[3] = '{1'b0, 32'h0000_3000, 32'h0,         1'b0, 4'h0, 32'h5555_6666, 2, 1'b1, 2'b01, 1'b0, 4'hF};
    vecs[4] = '{1'b1, 32'h0000_4000, 32'h1234_5678, 1'b1, 4'h1, 32'h0,         0, 1'b1, 2'b10, 1'b1, 4'h1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 4'h0, 32'h7777_8888, 5, 1'b0, 2'b01, 1'b0, 4'hF};
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // reset state, with a request held during reset
    idle_inputs();
    i_cyc_i = 1; i_stb_i = 1;
    repeat (2) tick();
    #1;
    chk("reset grant", grant_o, 2'b00);
    chk("reset ctrl", {s_cyc_o, s_stb_o, s_we_o, i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o}, 8'h00);
    rst_n = 1;
    go_idle();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // single data read timing
    go_idle();
    d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h80;
    tick(); #1;
    chk("rd c1 grant", grant_o, 2'b10);
    chk("rd c1 s_cyc", {s_cyc_o, s_stb_o}, 2'b11);
    chk("rd c1 ack", d_ack_o, 1'b0);
    tick();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("rd c2 grant", grant_o, 2'b10);
    chk("rd c2 d_ack", d_ack_o, 1'b1);
    chk("rd c2 d_dat", d_dat_o, 32'hDEAD_BEEF);
    chk("rd c2 i_ack", i_ack_o, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk("rd c3 grant", grant_o, 2'b00);
    chk("rd c3 s_cyc", s_cyc_o, 1'b0);

    // instruction fetches at 0,4,8
    go_idle();
    d_we_i = 1; d_sel_i = 4'h2;
    for (int k = 0; k < 3; k++) begin
      i_cyc_i = 1; i_stb_i = 1; i_adr_i = 32'(k * 4);
      tick();
      s_ack_i = 1;
      #1;
      chk($sformatf("if%0d grant", k), grant_o, 2'b01);
      chk($sformatf("if%0d adr", k), s_adr_o, 32'(k * 4));
      chk($sformatf("if%0d we/sel", k), {s_we_o, s_sel_o}, 5'h0F);
      chk($sformatf("if%0d acks", k), {i_ack_o, d_ack_o}, 2'b10);
      tick();
      s_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
      #1;
      chk($sformatf("if%0d idle", k), grant_o, 2'b00);
      tick();
    end

    // fairness streak with both masters requesting continuously
    go_idle();
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      g = grant_o;
      chk($sformatf("order%0d", k), g, exp_order[k]);
      tick();
      s_ack_i = 1;
      #1;
      chk($sformatf("order%0d ack", k), {i_ack_o, d_ack_o}, {exp_order[k][0], exp_order[k][1]});
      tick();
      s_ack_i = 0;
    end

    // data master abandons its cycle, pending instruction fetch follows
    go_idle();
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    tick(); #1;
    chk("abandon grant d", grant_o, 2'b10);
    tick();
    tick();
    d_cyc_i = 0; d_stb_i = 0;
    #1;
    chk("abandon s_cyc", s_cyc_o, 1'b0);
    chk("abandon no resp", {d_ack_o, d_err_o, i_ack_o, i_err_o}, 4'h0);
    tick(); #1;
    chk("abandon idle", grant_o, 2'b00);
    tick();
    s_ack_i = 1;
    #1;
    chk("abandon grant i", grant_o, 2'b01);
    chk("abandon i_ack", i_ack_o, 1'b1);
    tick();
    idle_inputs();

    // watchdog abort of a hung data write
    go_idle();
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'hF; d_adr_i = 32'h100; d_dat_i = 32'h0BAD_F00D;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #3;
      if (s_cyc_o) cnt++;
      else break;
    end
    chk("wdog cyc count", cnt, 8);
    chk("wdog abort", {d_err_o, timeout_o, s_cyc_o, i_err_o, grant_o}, 6'b110000);
    d_cyc_i = 0; d_stb_i = 0;
    tick(); #1;
    chk("wdog after", {d_err_o, timeout_o}, 2'b00);
    tick();
    s_ack_i = 1;
    #1;
    chk("wdog late ack", {d_ack_o, i_ack_o, grant_o}, 4'h0);
    idle_inputs();

    // reset during an instruction grant
    go_idle();
    i_cyc_i = 1; i_stb_i = 1; i_adr_i = 32'h40;
    tick(); #1;
    chk("rst gnt_i", grant_o, 2'b01);
    rst_n = 0;
    tick();
    s_ack_i = 1;
    #1;
    chk("rst mid grant", grant_o, 2'b00);
    chk("rst mid ctrl", {s_cyc_o, s_stb_o, i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o}, 7'h00);
    rst_n = 1; s_ack_i = 0;
    tick();
    s_ack_i = 1; s_dat_i = 32'hCAFE_0001;
    #1;
    chk("rst fresh grant", grant_o, 2'b01);
    chk("rst fresh ack", i_ack_o, 1'b1);
    chk("rst fresh dat", i_dat_o, 32'hCAFE_0001);

    go_idle();
    run_random(2000);

    idle_inputs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the core's instruction port (iwb) and data port (dwb) share a single unified memory.
- Data port has priority; a streak counter guarantees instruction-fetch forward progress.
- A watchdog aborts hung slave cycles and returns an error to the master that owns the bus.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_DSTREAK, 4, max consecutive data grants while an instruction request is pending
- TIMEOUT, 64, cycles without ack/err before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- i_adr_i  in  AW  instruction address
- i_cyc_i  in  1  instruction cycle
- i_stb_i  in  1  instruction strobe
- i_dat_o  out  DW  instruction read data
- i_ack_o  out  1  instruction ack
- i_err_o  out  1  instruction error
- d_adr_i  in  AW  data address
- d_dat_i  in  DW  data write data
- d_we_i  in  1  data write enable
- d_sel_i  in  DW/8  data byte selects
- d_cyc_i  in  1  data cycle
- d_stb_i  in  1  data strobe
- d_dat_o  out  DW  data read data
- d_ack_o  out  1  data ack
- d_err_o  out  1  data error
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_we_o  out  1  slave write enable
- s_sel_o  out  DW/8  slave byte selects
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave error
- grant_o  out  2  current owner: 00 none, 01 instruction, 10 data
- timeout_o  out  1  one-cycle pulse when a cycle is aborted

Behaviour:
- State register: IDLE, GNT_I, GNT_D, ABORT.
- Reset:
  - state=IDLE, streak=0, wdog=0.
  - All s_* control outputs, ack/err outputs and timeout_o are 0; grant_o=00.
  - Reset asserted mid-transaction drops s_cyc_o at the next edge; no ack/err is issued for that cycle.
- Request definitions: req_i = i_cyc_i & i_stb_i; req_d = d_cyc_i & d_stb_i.
- IDLE arbitration:
  - req_d only -> GNT_D.
  - req_i only -> GNT_I.
  - Both pending -> GNT_D, unless streak == MAX_DSTREAK, then GNT_I.
  - Neither pending -> stay in IDLE.
- Streak counter:
  - Increments on each GNT_D entry while req_i is high.
  - Clears on GNT_I entry, or on any IDLE cycle with req_i low.
  - Saturates at MAX_DSTREAK.
- Grant latency: request sampled in IDLE at edge N; s_cyc_o/s_stb_o are high in cycle N+1.
- Slave bus during a grant:
  - s_adr/dat/we/sel/cyc/stb are combinational copies of the owning master's signals.
  - Instruction port drives we=0 and sel=all-ones.
  - In IDLE and ABORT, s_cyc_o=s_stb_o=0.
- Return path:
  - s_dat_i fans out to both *_dat_o.
  - s_ack_i/s_err_i route combinationally, same cycle, to the owner only.
  - The non-owner's ack/err are always 0.
- Completion:
  - Ack or err cycle in GNT_x -> IDLE at the next edge.
  - Exactly one idle bus cycle separates back-to-back transactions.
- Master abandon: owner drops cyc without ack -> s_cyc_o falls the same cycle; IDLE at next edge; no ack/err issued.
- Watchdog:
  - wdog clears on GNT entry and increments each GNT cycle without ack/err.
  - If TIMEOUT != 0 and wdog reaches TIMEOUT-1 with no ack/err, the state goes to ABORT.
- ABORT (exactly 1 cycle):
  - owner's *_err_o=1, timeout_o=1, s_cyc_o=0.
  - Then IDLE; the owner recorded at abort time is the one that receives err.
- Late s_ack_i/s_err_i arriving in IDLE or ABORT are ignored and never forwarded.
- Simultaneous ack and err from the slave: both are forwarded; the master treats err as dominant.

Test Plan:
- Single data read, req_d at edge 0, s_ack_i high in cycle 2 with s_dat_i=0xDEADBEEF -> grant_o=10 in cycles 1-2, d_ack_o=1 and d_dat_o=0xDEADBEEF in cycle 2, i_ack_o=0, IDLE in cycle 3.
- req_i and req_d both held continuously, slave acks each cycle after one wait -> grant order D,D,D,D,I,D,D,D,D,I.
- Instruction fetch only at addresses 0x0,0x4,0x8 -> three GNT_I transactions; s_we_o=0 and s_sel_o=0xF throughout.
- TIMEOUT=8, slave never acks a data write to 0x100 -> s_cyc_o high for 8 cycles; then d_err_o=1 and timeout_o=1 for 1 cycle, s_cyc_o=0; a late s_ack_i 2 cycles later is not forwarded.
- Owner drops d_cyc_i after 2 wait cycles -> s_cyc_o falls the same cycle; the pending req_i is granted 2 edges later.
- rst_n low for 1 cycle during GNT_I -> next cycle all outputs 0, grant_o=00; a fresh req_i afterwards completes normally.
